ysyx_2022040010_sram_arb: RTL and testbench

Single-port memory arbiter sitting directly downstream of the five-stage core's instruction and data SRAM ports. Each cycle the core may present one instruction fetch and one data access. The block serialises them onto one valid/ready memory bus with variable response latency. It holds the core with `stall_req` until both accesses have completed.

---
 rtl/ysyx_2022040010_sram_arb.sv | 232 +++++++++++++++++++++++
 tb/tb_ysyx_2022040010_sram_arb.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_2022040010_sram_arb.sv
// rtl/ysyx_2022040010_sram_arb.sv - serialises core fetch and data SRAM accesses onto one memory bus
//
// Optional feature macro: YSYX_2022040010_ARB_IBUF_EN
//   When defined, a one-entry fetch line buffer lets a fetch that hits the
//   buffered line finish without touching the bus.
//
// Ports:
//   clk, rst           clock (rising edge) and synchronous active-low reset
//   isram_e            fetch request from the core
//   isram_addr         fetch byte address (4-byte aligned)
//   isram_rdata        fetched instruction, registered, valid from DONE
//   dsram_e            data access request from the core
//   dsram_we           1 = store, 0 = load
//   dsram_addr         data byte address
//   dsram_wdata        store data
//   dsram_sel          store byte strobes
//   dsram_rdata        load data, registered, valid from DONE
//   stall_req          core holds its request inputs stable while high
//   mem_req_valid      bus request valid, held until mem_req_ready
//   mem_req_ready      bus accepts the request
//   mem_addr           8-byte aligned bus address
//   mem_we             bus write enable
//   mem_wdata          bus write data
//   mem_wstrb          bus write strobes
//   mem_resp_valid     response beat, one per accepted request
//   mem_resp_rdata     response read data

module ysyx_2022040010_sram_arb #(
    parameter int MEM_AW = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              isram_e,
    input  logic [63:0]       isram_addr,
    output logic [31:0]       isram_rdata,

    input  logic              dsram_e,
    input  logic              dsram_we,
    input  logic [63:0]       dsram_addr,
    input  logic [63:0]       dsram_wdata,
    input  logic [7:0]        dsram_sel,
    output logic [63:0]       dsram_rdata,

    output logic              stall_req,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_wstrb,
    input  logic              mem_resp_valid,
    input  logic [63:0]       mem_resp_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_REQ  = 3'd1,
        D_WAIT = 3'd2,
        I_REQ  = 3'd3,
        I_WAIT = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state;
    state_t state_n;

    // Line-aligned forms of both request addresses.
    logic [63:0] d_line;
    logic [63:0] i_line;

    // Fetch serviced from the line buffer instead of the bus this cycle.
    logic        ibuf_hit;
    logic        ibuf_take;
    logic [63:0] ibuf_line;

    // Sub-line address bits never reach the bus; the fetch word select
    // uses isram_addr[2] directly.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{isram_addr[1:0], dsram_addr[2:0]};

    assign d_line = {dsram_addr[63:3], 3'b000};
    assign i_line = {isram_addr[63:3], 3'b000};

    function automatic logic [31:0] fetch_word(input logic [63:0] line, input logic hi);
        return hi ? line[63:32] : line[31:0];
    endfunction

`ifdef YSYX_2022040010_ARB_IBUF_EN
    logic        ibuf_valid;
    logic [60:0] ibuf_tag;

    assign ibuf_hit = ibuf_valid && (ibuf_tag == isram_addr[63:3]);

    // Filled by every bus fetch; dropped by a store to the buffered line
    // at the moment the store is accepted, so a fetch following that store
    // in the same core cycle already sees the entry as invalid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ibuf_valid <= 1'b0;
            ibuf_tag   <= '0;
            ibuf_line  <= '0;
        end else if (state == I_WAIT && mem_resp_valid) begin
            ibuf_valid <= 1'b1;
            ibuf_tag   <= isram_addr[63:3];
            ibuf_line  <= mem_resp_rdata;
        end else if (state == D_REQ && mem_req_ready && dsram_we &&
                     ibuf_tag == dsram_addr[63:3]) begin
            ibuf_valid <= 1'b0;
        end
    end
`else
    assign ibuf_hit  = 1'b0;
    assign ibuf_line = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        ibuf_take = 1'b0;
        case (state)
            IDLE: begin
                if (dsram_e) begin
                    state_n = D_REQ;
                end else if (isram_e) begin
                    if (ibuf_hit) begin
                        state_n   = DONE;
                        ibuf_take = 1'b1;
                    end else begin
                        state_n = I_REQ;
                    end
                end
            end
            D_REQ: begin
                if (mem_req_ready) begin
                    state_n = D_WAIT;
                end
            end
            D_WAIT: begin
                if (mem_resp_valid) begin
                    if (!isram_e) begin
                        state_n = DONE;
                    end else if (ibuf_hit) begin
                        state_n   = DONE;
                        ibuf_take = 1'b1;
                    end else begin
                        state_n = I_REQ;
                    end
                end
            end
            I_REQ: begin
                if (mem_req_ready) begin
                    state_n = I_WAIT;
                end
            end
            I_WAIT: begin
                if (mem_resp_valid) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // The IDLE term makes the stall visible in the same cycle the core
    // raises a request, before the FSM has left IDLE.
    always_comb begin
        stall_req = 1'b0;
        case (state)
            IDLE:                          stall_req = isram_e || dsram_e;
            D_REQ, D_WAIT, I_REQ, I_WAIT:  stall_req = 1'b1;
            default:                       stall_req = 1'b0;
        endcase
    end

    // Request fields are loaded only on entry to a REQ state, so they stay
    // frozen for as long as the bus withholds ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
        end else begin
            mem_req_valid <= (state_n == D_REQ) || (state_n == I_REQ);
            if (state != D_REQ && state_n == D_REQ) begin
                mem_addr  <= d_line[MEM_AW-1:0];
                mem_we    <= dsram_we;
                mem_wdata <= dsram_wdata;
                mem_wstrb <= dsram_sel;
            end else if (state != I_REQ && state_n == I_REQ) begin
                mem_addr  <= i_line[MEM_AW-1:0];
                mem_we    <= 1'b0;
                mem_wdata <= '0;
                mem_wstrb <= '0;
            end
        end
    end

    // Read data registers: stores still consume their response beat but
    // never disturb dsram_rdata.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dsram_rdata <= '0;
            isram_rdata <= '0;
        end else begin
            if (state == D_WAIT && mem_resp_valid && !dsram_we) begin
                dsram_rdata <= mem_resp_rdata;
            end
            if (state == I_WAIT && mem_resp_valid) begin
                isram_rdata <= fetch_word(mem_resp_rdata, isram_addr[2]);
            end else if (ibuf_take) begin
                isram_rdata <= fetch_word(ibuf_line, isram_addr[2]);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_2022040010_sram_arb.sv
// tb/tb_ysyx_2022040010_sram_arb.sv - self-checking bench for ysyx_2022040010_sram_arb

module tb_ysyx_2022040010_sram_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        isram_e;
    logic [63:0] isram_addr;
    logic [31:0] isram_rdata;
    logic        dsram_e;
    logic        dsram_we;
    logic [63:0] dsram_addr;
    logic [63:0] dsram_wdata;
    logic [7:0]  dsram_sel;
    logic [63:0] dsram_rdata;
    logic        stall_req;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;

    always #5 clk = ~clk;

    ysyx_2022040010_sram_arb #(.MEM_AW(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .isram_e        (isram_e),
        .isram_addr     (isram_addr),
        .isram_rdata    (isram_rdata),
        .dsram_e        (dsram_e),
        .dsram_we       (dsram_we),
        .dsram_addr     (dsram_addr),
        .dsram_wdata    (dsram_wdata),
        .dsram_sel      (dsram_sel),
        .dsram_rdata    (dsram_rdata),
        .stall_req      (stall_req),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
    );

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [7:0]  wstrb;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          ready_delay;
    } bus_t;

    typedef struct {
        logic        d_e;
        logic        d_we;
        logic [63:0] d_addr;
        logic [63:0] d_wdata;
        logic [7:0]  d_sel;
        logic [63:0] d_mem;
        int          d_dly;
        logic        i_e;
        logic [63:0] i_addr;
        logic [63:0] i_mem;
        int          i_dly;
        logic        i_bus;
        logic [63:0] exp_d;
        logic [31:0] exp_i;
        int          exp_cyc;
    } vec_t;

    bus_t        exp_bus[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          hold_cnt = 0;
    logic        resp_pend = 1'b0;
    logic [63:0] pend_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic d_e, input logic d_we, input logic [63:0] d_addr,
                                input logic [63:0] d_wdata, input logic [7:0] d_sel,
                                input logic [63:0] d_mem, input int d_dly,
                                input logic i_e, input logic [63:0] i_addr,
                                input logic [63:0] i_mem, input int i_dly, input logic i_bus,
                                input logic [63:0] exp_d, input logic [31:0] exp_i,
                                input int exp_cyc);
        vec_t v;
        v.d_e = d_e;     v.d_we = d_we;   v.d_addr = d_addr; v.d_wdata = d_wdata;
        v.d_sel = d_sel; v.d_mem = d_mem; v.d_dly = d_dly;
        v.i_e = i_e;     v.i_addr = i_addr; v.i_mem = i_mem; v.i_dly = i_dly; v.i_bus = i_bus;
        v.exp_d = exp_d; v.exp_i = exp_i; v.exp_cyc = exp_cyc;
        return v;
    endfunction

    // Memory model, called once per negedge: checks the presented request
    // against the head of the expected-bus queue, withholds ready for the
    // record's delay, and returns its data one cycle after acceptance.
    task automatic mem_step();
        bus_t b;
        mem_resp_valid = 1'b0;
        if (resp_pend) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = pend_data;
            resp_pend      = 1'b0;
        end
        if (mem_req_valid) begin
            if (exp_bus.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL bus_unexpected: got request addr 0x%0h required no request", mem_addr);
                mem_req_ready = 1'b0;
            end else begin
                b = exp_bus[0];
                check("bus_addr", mem_addr, b.addr);
                check("bus_we", {63'b0, mem_we}, {63'b0, b.we});
                check("bus_wstrb", {56'b0, mem_wstrb}, {56'b0, b.wstrb});
                if (b.we) check("bus_wdata", mem_wdata, b.wdata);
                if (hold_cnt < b.ready_delay) begin
                    mem_req_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    mem_req_ready = 1'b1;
                    pend_data     = b.rdata;
                    resp_pend     = 1'b1;
                    hold_cnt      = 0;
                    void'(exp_bus.pop_front());
                end
            end
        end else begin
            if (hold_cnt != 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL bus_retract: got valid 0 required 1 after %0d held cycles", hold_cnt);
                hold_cnt = 0;
            end
            mem_req_ready = 1'b0;
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        bus_t b;
        int   cyc;
        logic done;
        @(negedge clk);
        dsram_e     = v.d_e;
        dsram_we    = v.d_we;
        dsram_addr  = v.d_addr;
        dsram_wdata = v.d_wdata;
        dsram_sel   = v.d_sel;
        isram_e     = v.i_e;
        isram_addr  = v.i_addr;
        if (v.d_e) begin
            b.addr = v.d_addr & ~64'h7; b.we = v.d_we; b.wstrb = v.d_sel;
            b.wdata = v.d_wdata; b.rdata = v.d_mem; b.ready_delay = v.d_dly;
            exp_bus.push_back(b);
        end
        if (v.i_e && v.i_bus) begin
            b.addr = v.i_addr & ~64'h7; b.we = 1'b0; b.wstrb = 8'h00;
            b.wdata = '0; b.rdata = v.i_mem; b.ready_delay = v.i_dly;
            exp_bus.push_back(b);
        end
        mem_step();
        #1;
        check($sformatf("stall_on_request[%0d]", idx), {63'b0, stall_req}, 64'd1);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            mem_step();
            #1;
            cyc++;
            if (!stall_req) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout[%0d]: got stall_req 1 after %0d cycles required 0", idx, cyc);
            exp_bus.delete();
        end else begin
            check($sformatf("latency[%0d]", idx), 64'(cyc), 64'(v.exp_cyc));
            check($sformatf("dsram_rdata[%0d]", idx), dsram_rdata, v.exp_d);
            check($sformatf("isram_rdata[%0d]", idx), {32'b0, isram_rdata}, {32'b0, v.exp_i});
            check($sformatf("bus_drained[%0d]", idx), 64'(exp_bus.size()), 64'd0);
        end
        dsram_e = 1'b0;
        isram_e = 1'b0;
    endtask

    vec_t tbl[6];
`ifdef YSYX_2022040010_ARB_IBUF_EN
    vec_t ibt[4];
`endif

    initial begin
        tbl[0] = mk(0, 0, 64'h0, 64'h0, 8'h00, 64'h0, 0,
                    1, 64'h8000_0004, 64'h1234_5678_9ABC_DEF0, 0, 1,
                    64'h0, 32'h1234_5678, 3);
        tbl[1] = mk(1, 0, 64'h8000_1000, 64'h0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D, 0,
                    1, 64'h8000_0100, 64'h1111_2222_3333_4444, 0, 1,
                    64'hDEAD_BEEF_CAFE_F00D, 32'h3333_4444, 5);
        tbl[2] = mk(1, 1, 64'h8000_2008, 64'hA5A5_A5A5_5A5A_5A5A, 8'h0F, 64'hBAD0_BAD0_BAD0_BAD0, 3,
                    0, 64'h0, 64'h0, 0, 0,
                    64'hDEAD_BEEF_CAFE_F00D, 32'h3333_4444, 6);
        tbl[3] = mk(1, 0, 64'h8000_3006, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 1,
                    0, 64'h0, 64'h0, 0, 0,
                    64'h0123_4567_89AB_CDEF, 32'h3333_4444, 4);
        tbl[4] = mk(1, 1, 64'h8000_4000, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, 64'h7777_7777_7777_7777, 0,
                    1, 64'h8000_4004, 64'hCAFE_BABE_0000_0000, 0, 1,
                    64'h0123_4567_89AB_CDEF, 32'hCAFE_BABE, 5);
        tbl[5] = mk(0, 0, 64'h0, 64'h0, 8'h00, 64'h0, 0,
                    1, 64'h0000_0010, 64'h5555_6666_7777_8888, 2, 1,
                    64'h0123_4567_89AB_CDEF, 32'h7777_8888, 5);
`ifdef YSYX_2022040010_ARB_IBUF_EN
        ibt[0] = mk(0, 0, 64'h0, 64'h0, 8'h00, 64'h0, 0,
                    1, 64'h8000_0000, 64'h0BAD_F00D_1357_2468, 0, 1,
                    64'h0, 32'h1357_2468, 3);
        ibt[1] = mk(0, 0, 64'h0, 64'h0, 8'h00, 64'h0, 0,
                    1, 64'h8000_0004, 64'h0, 0, 0,
                    64'h0, 32'h0BAD_F00D, 1);
        ibt[2] = mk(1, 1, 64'h8000_0000, 64'h1, 8'hFF, 64'h0, 0,
                    0, 64'h0, 64'h0, 0, 0,
                    64'h0, 32'h0BAD_F00D, 3);
        ibt[3] = mk(0, 0, 64'h0, 64'h0, 8'h00, 64'h0, 0,
                    1, 64'h8000_0000, 64'h2222_2222_4444_4444, 0, 1,
                    64'h0, 32'h4444_4444, 3);
`endif

        rst            = 1'b0;
        isram_e        = 1'b1;
        isram_addr     = 64'h8000_0000;
        dsram_e        = 1'b0;
        dsram_we       = 1'b0;
        dsram_addr     = '0;
        dsram_wdata    = '0;
        dsram_sel      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;

        // Reset held two cycles with a fetch pending.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_req_valid", {63'b0, mem_req_valid}, 64'd0);
        check("rst_isram_rdata", {32'b0, isram_rdata}, 64'd0);
        check("rst_dsram_rdata", dsram_rdata, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_fields", {mem_wdata[55:0], mem_wstrb}, 64'd0);
        check("rst_mem_we", {63'b0, mem_we}, 64'd0);
        check("rst_idle_stall", {63'b0, stall_req}, 64'd1);
        isram_e = 1'b0;
        #1;
        check("rst_idle_nostall", {63'b0, stall_req}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i], i);
        end

        // Reset while the fetch waits in I_WAIT; the late beat must be ignored.
        @(negedge clk);
        isram_e    = 1'b1;
        isram_addr = 64'h8000_0008;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        #1;
        check("irq_valid", {63'b0, mem_req_valid}, 64'd1);
        check("irq_addr", mem_addr, 64'h8000_0008);
        @(negedge clk);
        #1;
        check("iwait_valid_low", {63'b0, mem_req_valid}, 64'd0);
        check("iwait_stall", {63'b0, stall_req}, 64'd1);
        rst           = 1'b0;
        mem_req_ready = 1'b0;
        @(negedge clk);
        rst            = 1'b1;
        isram_e        = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hFFFF_EEEE_DDDD_CCCC;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        check("late_resp_isram", {32'b0, isram_rdata}, 64'd0);
        check("late_resp_dsram", dsram_rdata, 64'd0);
        check("late_resp_stall", {63'b0, stall_req}, 64'd0);
        check("late_resp_valid", {63'b0, mem_req_valid}, 64'd0);
        @(negedge clk);
        #1;
        check("late_resp_settled", {63'b0, mem_req_valid}, 64'd0);
        hold_cnt  = 0;
        resp_pend = 1'b0;

`ifdef YSYX_2022040010_ARB_IBUF_EN
        for (int i = 0; i < 4; i++) begin
            run_txn(ibt[i], 10 + i);
        end
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
